// File: rtl/wb_regfile.sv
// Write-back select, 32-entry register file with write-first bypass
// and a retired-write counter.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              RegWrite_i,
  input  logic              MemToReg_i,
  input  logic [DATA_W-1:0] Memdata_i,
  input  logic [DATA_W-1:0] ALUdata_i,
  input  logic [ADDR_W-1:0] RDaddr_i,
  input  logic [ADDR_W-1:0] RS1addr_i,
  input  logic [ADDR_W-1:0] RS2addr_i,
  output logic [DATA_W-1:0] RS1data_o,
  output logic [DATA_W-1:0] RS2data_o,
  output logic [DATA_W-1:0] WBdata_o,
  output logic              WBvalid_o,
  output logic [CNT_W-1:0]  WrCount_o
);

  localparam int N = 2**ADDR_W;

  logic [DATA_W-1:0] regs [N];
  logic [CNT_W-1:0]  cnt;
  logic              we;

  assign WBdata_o  = MemToReg_i ? Memdata_i : ALUdata_i;
  assign WBvalid_o = RegWrite_i & (RDaddr_i != '0);
  assign we        = rst_i & WBvalid_o;
  assign WrCount_o = cnt;

  // r0 is never written because we requires a non-zero destination
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int i = 0; i < N; i++)
        regs[i] <= '0;
      cnt <= '0;
    end else if (we) begin
      regs[RDaddr_i] <= WBdata_o;
      cnt <= cnt + CNT_W'(1);
    end
  end

  function automatic logic [DATA_W-1:0] rd(
    input logic [ADDR_W-1:0] a
  );
    logic [DATA_W-1:0] d;
    if (!rst_i)
      d = '0;
    else if (a == '0)
      d = '0;
    else if (we && (a == RDaddr_i))
      d = WBdata_o;
    else
      d = regs[a];
    return d;
  endfunction

  always_comb begin
    RS1data_o = rd(RS1addr_i);
    RS2data_o = rd(RS2addr_i);
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile; a second
// instance with CNT_W=4 covers counter wrap.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        rw;
  logic        m2r;
  logic [31:0] md;
  logic [31:0] ad;
  logic [4:0]  rd;
  logic [4:0]  a1;
  logic [4:0]  a2;

  logic [31:0] rs1, rs2, wb, cnt;
  logic        vld;
  logic [31:0] rs1b, rs2b, wbb;
  logic        vldb;
  logic [3:0]  c4;

  always #5 clk = ~clk;

  wb_regfile u_dut (
    .clk_i(clk), .rst_i(rst),
    .RegWrite_i(rw), .MemToReg_i(m2r),
    .Memdata_i(md), .ALUdata_i(ad),
    .RDaddr_i(rd),
    .RS1addr_i(a1), .RS2addr_i(a2),
    .RS1data_o(rs1), .RS2data_o(rs2),
    .WBdata_o(wb), .WBvalid_o(vld),
    .WrCount_o(cnt)
  );

  wb_regfile #(.CNT_W(4)) u_dut4 (
    .clk_i(clk), .rst_i(rst),
    .RegWrite_i(rw), .MemToReg_i(m2r),
    .Memdata_i(md), .ALUdata_i(ad),
    .RDaddr_i(rd),
    .RS1addr_i(a1), .RS2addr_i(a2),
    .RS1data_o(rs1b), .RS2data_o(rs2b),
    .WBdata_o(wbb), .WBvalid_o(vldb),
    .WrCount_o(c4)
  );

  typedef struct {
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] wb;
    logic        vld;
    logic [31:0] cnt;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mreg [32];
  logic [31:0] mcnt;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h",
               tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      chk("rs1", rs1, e.r1);
      chk("rs2", rs2, e.r2);
      chk("wb", wb, e.wb);
      chk("vld", {31'b0, vld}, {31'b0, e.vld});
      chk("cnt", cnt, e.cnt);
      chk("cnt4", {28'b0, c4}, {28'b0, e.cnt[3:0]});
      chk("rs1b", rs1b, e.r1);
    end
  end

  function automatic logic [31:0] mrd(
    input logic [4:0] a,
    input logic       we,
    input logic [31:0] w
  );
    if (!rst || a == 5'd0) return 32'h0;
    if (we && a == rd) return w;
    return mreg[a];
  endfunction

  task automatic step(
    input logic        r,
    input logic        w,
    input logic        s,
    input logic [31:0] m,
    input logic [31:0] al,
    input logic [4:0]  d,
    input logic [4:0]  p1,
    input logic [4:0]  p2
  );
    exp_t        e;
    logic [31:0] wv;
    logic        we;
    @(posedge clk);
    #2;
    rst = r; rw = w; m2r = s;
    md = m; ad = al; rd = d;
    a1 = p1; a2 = p2;
    wv = s ? m : al;
    we = r & w & (d != 5'd0);
    e.r1  = mrd(p1, we, wv);
    e.r2  = mrd(p2, we, wv);
    e.wb  = wv;
    e.vld = w & (d != 5'd0);
    e.cnt = mcnt;
    q.push_back(e);
    if (!r) begin
      for (int i = 0; i < 32; i++)
        mreg[i] = 32'h0;
      mcnt = 32'h0;
    end else if (we) begin
      mreg[d] = wv;
      mcnt = mcnt + 32'd1;
    end
  endtask

  task automatic idle(
    input logic [4:0] p1,
    input logic [4:0] p2
  );
    step(1'b1, 1'b0, 1'b0, 32'hAAAA_AAAA,
         32'hBBBB_BBBB, p1, p1, p2);
  endtask

  initial begin
    rst = 1'b0; rw = 1'b0; m2r = 1'b0;
    md = '0; ad = '0; rd = '0;
    a1 = '0; a2 = '0;
    mcnt = 32'h0;
    for (int i = 0; i < 32; i++)
      mreg[i] = 32'hX;

    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 32; i++)
      idle(5'(i), 5'(31 - i));

    step(1, 1, 0, 32'hDEAD_BEEF,
         32'h0000_1234, 5, 5, 6);
    step(1, 1, 1, 32'hDEAD_BEEF,
         32'h0000_1234, 6, 5, 6);
    idle(5, 6);

    step(1, 1, 0, 0, 32'hCAFE_F00D, 7, 7, 7);
    idle(7, 7);

    step(1, 1, 0, 0, 32'hFFFF_FFFF, 0, 0, 7);
    idle(0, 0);

    @(posedge clk);
    #2 rst = 1'b0;
    #2 rst = 1'b1;
    idle(7, 5);

    step(1, 1, 0, 0, 32'h11, 3, 3, 4);
    step(0, 1, 0, 0, 32'h22, 4, 3, 4);
    idle(3, 4);
    step(1, 1, 0, 0, 32'h33, 2, 2, 3);
    idle(2, 3);

    step(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 17; i++)
      step(1, 1, 0, 0, 32'(i + 100), 1, 1, 0);
    idle(1, 2);

    for (int i = 0; i < 40; i++)
      step(1'($urandom_range(0, 9) != 0),
           1'($urandom), 1'($urandom),
           $urandom, $urandom,
           5'($urandom), 5'($urandom),
           5'($urandom));

    @(negedge clk);
    #1;
    chk("q_empty", 32'(q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d",
             checks, errors);
    $finish;
  end

endmodule
